// File: rtl/lfsr_encrypt_stage_pkg.sv
// rtl/lfsr_encrypt_stage_pkg.sv - shared constants, state type and helpers for the LFSR frame encrypter
// Contents: frame geometry, preamble character, tap pattern lookup, FSM state
// enum and the preamble-length clamp. Shared with the downstream decrypter.
package lfsr_encrypt_stage_pkg;

    localparam logic [7:0] SRC_BASE      = 8'd0;
    localparam logic [7:0] DST_BASE      = 8'd64;
    localparam int         FRAME_LEN     = 64;
    localparam int         PRE_MIN       = 7;
    localparam int         PRE_MAX       = 12;
    localparam logic [7:0] PREAMBLE_CHAR = 8'h5f;
    localparam int         NUM_TAPS      = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        MSG  = 2'd2,
        DONE = 2'd3
    } enc_state_t;

    // The six feedback patterns the decrypter searches over; any other index
    // is rejected before it ever reaches the LFSR.
    function automatic logic [5:0] tap_pattern(input logic [2:0] sel);
        case (sel)
            3'd0:    return 6'h21;
            3'd1:    return 6'h2D;
            3'd2:    return 6'h30;
            3'd3:    return 6'h33;
            3'd4:    return 6'h36;
            3'd5:    return 6'h39;
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [6:0] clamp_pre_len(input logic [4:0] len);
        logic [6:0] l;
        l = {2'b00, len};
        if (l < 7'(PRE_MIN)) begin
            l = 7'(PRE_MIN);
        end else if (l > 7'(PRE_MAX)) begin
            l = 7'(PRE_MAX);
        end
        return l;
    endfunction

endpackage

// File: rtl/lfsr_encrypt_stage_if.sv
// rtl/lfsr_encrypt_stage_if.sv - data memory port between the encrypter and dat_mem
// Signals: raddr (read address), data_out (combinational read data),
// wr_en/waddr/data_in (write port). master = encrypter, slave = memory.
interface lfsr_encrypt_stage_if;

    logic [7:0] raddr;
    logic [7:0] data_out;
    logic       wr_en;
    logic [7:0] waddr;
    logic [7:0] data_in;

    modport master (
        output raddr,
        input  data_out,
        output wr_en,
        output waddr,
        output data_in
    );

    modport slave (
        input  raddr,
        output data_out,
        input  wr_en,
        input  waddr,
        input  data_in
    );

endinterface

// File: rtl/lfsr_encrypt_stage_lfsr6b.sv
// rtl/lfsr_encrypt_stage_lfsr6b.sv - 6-bit Fibonacci LFSR with load and step enable
// Ports: clk, init_n (sync active-low reset), init_i (load seed_i),
// en_i (advance one step using taps_i), seed_i, taps_i, state_o (current state).
module lfsr6b (
    input  logic       clk,
    input  logic       init_n,
    input  logic       init_i,
    input  logic       en_i,
    input  logic [5:0] seed_i,
    input  logic [5:0] taps_i,
    output logic [5:0] state_o
);

    logic [5:0] state_q;
    logic [5:0] state_d;

    always_comb begin
        state_d = state_q;
        if (init_i) begin
            state_d = seed_i;
        end else if (en_i) begin
            state_d = {state_q[4:0], ^(state_q & taps_i)};
        end
    end

    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_q <= 6'd0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lfsr_encrypt_stage.sv
// rtl/lfsr_encrypt_stage.sv - builds the 64-byte LFSR-encrypted frame (preamble + message) in dat_mem
// Ports: clk, init_n (sync active-low reset), start_i (request pulse),
// tap_sel_i (tap pattern index 0..5), seed_i (nonzero LFSR seed),
// pre_len_i (requested preamble length), mem (dat_mem master port),
// done_o (frame complete, sticky), err_o (last start rejected, sticky).
// Build option: ENC_PARITY_EN replaces data_in[7] with even parity over data_in[6:0].
module lfsr_encrypt_stage
    import lfsr_encrypt_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        init_n,
    input  logic                        start_i,
    input  logic [2:0]                  tap_sel_i,
    input  logic [5:0]                  seed_i,
    input  logic [4:0]                  pre_len_i,
    lfsr_encrypt_stage_if.master        mem,
    output logic                        done_o,
    output logic                        err_o
);

    localparam logic [6:0] LAST_CNT = 7'(FRAME_LEN - 1);

    enc_state_t state_q;
    logic [6:0] cnt_q;
    logic [6:0] plen_q;
    logic [5:0] taps_q;
    logic       done_q;
    logic       err_q;
    logic [5:0] lfsr;

    logic       idle_or_done;
    logic       start_legal;
    logic       start_accept;
    logic       write_cycle;
    logic [6:0] msg_idx;
    logic [7:0] byte_d;

    assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
    assign start_legal  = (tap_sel_i < 3'(NUM_TAPS)) && (seed_i != 6'd0);
    assign start_accept = idle_or_done && start_i && start_legal;
    assign write_cycle  = (state_q == PRE) || (state_q == MSG);
    assign msg_idx      = cnt_q - plen_q;

    // The seed loads on the accept edge, so the first write cycle already
    // sees the seed and each later write sees one more step.
    lfsr6b u_lfsr (
        .clk     (clk),
        .init_n  (init_n),
        .init_i  (start_accept),
        .en_i    (write_cycle),
        .seed_i  (seed_i),
        .taps_i  (taps_q),
        .state_o (lfsr)
    );

    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_q <= IDLE;
            cnt_q   <= 7'd0;
            plen_q  <= 7'(PRE_MIN);
            taps_q  <= 6'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        done_q <= 1'b0;
                        if (start_legal) begin
                            taps_q  <= tap_pattern(tap_sel_i);
                            plen_q  <= clamp_pre_len(pre_len_i);
                            cnt_q   <= 7'd0;
                            err_q   <= 1'b0;
                            state_q <= PRE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (state_q == DONE) begin
                        // done follows one cycle after entering DONE.
                        done_q <= 1'b1;
                    end
                end
                PRE: begin
                    cnt_q <= cnt_q + 7'd1;
                    if (cnt_q == plen_q - 7'd1) begin
                        state_q <= MSG;
                    end
                end
                MSG: begin
                    cnt_q <= cnt_q + 7'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem.wr_en   = 1'b0;
        mem.raddr   = SRC_BASE;
        mem.waddr   = DST_BASE;
        mem.data_in = 8'd0;
        byte_d      = 8'd0;
        if (write_cycle) begin
            mem.wr_en = 1'b1;
            mem.waddr = DST_BASE + {1'b0, cnt_q};
            if (state_q == PRE) begin
                byte_d = {PREAMBLE_CHAR[7:6], PREAMBLE_CHAR[5:0] ^ lfsr};
            end else begin
                mem.raddr = SRC_BASE + {1'b0, msg_idx};
                byte_d    = {mem.data_out[7:6], mem.data_out[5:0] ^ lfsr};
            end
`ifdef ENC_PARITY_EN
            mem.data_in = {^byte_d[6:0], byte_d[6:0]};
`else
            mem.data_in = byte_d;
`endif
        end
    end

    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_lfsr_encrypt_stage.sv
// tb/tb_lfsr_encrypt_stage.sv - self-checking scoreboard bench for lfsr_encrypt_stage
module tb_lfsr_encrypt_stage;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] raddr;
        logic       chk_raddr;
    } exp_t;

    logic       clk = 1'b0;
    logic       init_n;
    logic       start;
    logic [2:0] tap_sel;
    logic [5:0] seed;
    logic [4:0] pre_len;
    logic       done;
    logic       err;
    logic [7:0] mem [256];
    exp_t       sb [$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    lfsr_encrypt_stage_if mem_if ();

    lfsr_encrypt_stage dut (
        .clk       (clk),
        .init_n    (init_n),
        .start_i   (start),
        .tap_sel_i (tap_sel),
        .seed_i    (seed),
        .pre_len_i (pre_len),
        .mem       (mem_if.master),
        .done_o    (done),
        .err_o     (err)
    );

    assign mem_if.data_out = mem[mem_if.raddr];
    always @(posedge clk) begin
        if (mem_if.wr_en) mem[mem_if.waddr] <= mem_if.data_in;
    end

    function automatic logic [5:0] tb_taps(input int i);
        case (i)
            0: return 6'h21;
            1: return 6'h2D;
            2: return 6'h30;
            3: return 6'h33;
            4: return 6'h36;
            default: return 6'h39;
        endcase
    endfunction

    function automatic int tb_clamp(input int pl);
        return (pl < 7) ? 7 : ((pl > 12) ? 12 : pl);
    endfunction

    function automatic logic [7:0] fix_par(input logic [7:0] b);
`ifdef ENC_PARITY_EN
        return {^b[6:0], b[6:0]};
`else
        return b;
`endif
    endfunction

    task automatic push_frame(input int ts, input logic [5:0] sd, input int pl);
        int p;
        logic [5:0] lf;
        logic [7:0] m;
        exp_t e;
        p  = tb_clamp(pl);
        lf = sd;
        for (int c = 0; c < 64; c++) begin
            e.addr = 8'(64 + c);
            if (c < p) begin
                e.data = fix_par({2'b01, 6'h1f ^ lf});
                e.raddr = 8'd0;
                e.chk_raddr = 1'b0;
            end else begin
                m = mem[c - p];
                e.data = fix_par({m[7:6], m[5:0] ^ lf});
                e.raddr = 8'(c - p);
                e.chk_raddr = 1'b1;
            end
            sb.push_back(e);
            lf = {lf[4:0], ^(lf & tb_taps(ts))};
        end
    endtask

    // Drives one start and watches writes until done; busy_at/rst_at name the
    // write number at which a stray start or a reset is injected (0 = never).
    task automatic run_frame(input int ts, input logic [5:0] sd, input int pl,
                             input int busy_at, input int rst_at,
                             output int done_edge, output int nwr);
        exp_t e;
        int edges;
        bit stop;
        sb.delete();
        push_frame(ts, sd, pl);
        @(negedge clk);
        start = 1'b1; tap_sel = 3'(ts); seed = sd; pre_len = 5'(pl);
        @(posedge clk);
        #1;
        start = 1'b0; tap_sel = 3'd3; seed = 6'h2a; pre_len = 5'd9;
        edges = 0; nwr = 0; done_edge = -1; stop = 1'b0;
        while (!stop && done_edge < 0 && edges < 100) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_edge = edges;
            end else if (mem_if.wr_en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: write to %0h data %0h with nothing expected",
                             mem_if.waddr, mem_if.data_in);
                end else begin
                    e = sb.pop_front();
                    if ({mem_if.waddr, mem_if.data_in} !== {e.addr, e.data}) begin
                        errors++;
                        $display("FAIL write_%0d: addr/data %0h/%0h expected %0h/%0h",
                                 nwr, mem_if.waddr, mem_if.data_in, e.addr, e.data);
                    end
                    if (e.chk_raddr && mem_if.raddr !== e.raddr) begin
                        errors++;
                        $display("FAIL raddr_%0d: got %0h expected %0h", nwr, mem_if.raddr, e.raddr);
                    end
                end
                nwr++;
                if (nwr == busy_at) start = 1'b1;
                if (nwr == rst_at) begin
                    init_n = 1'b0;
                    @(negedge clk);
                    checks++;
                    if (mem_if.wr_en !== 1'b0 || done !== 1'b0) begin
                        errors++;
                        $display("FAIL mid_reset: wr_en %b done %b expected 0 0", mem_if.wr_en, done);
                    end
                    init_n = 1'b1;
                    sb.delete();
                    stop = 1'b1;
                end
            end
            if (!stop) begin
                @(posedge clk);
                edges++;
            end
        end
        if (!stop && done_edge < 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within %0d edges", edges);
        end
    endtask

    task automatic check_full(input string name, input int done_edge, input int nwr);
        checks++;
        if (done_edge != 65 || nwr != 64 || sb.size() != 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s: done_edge %0d writes %0d left %0d err %b expected 65 64 0 0",
                     name, done_edge, nwr, sb.size(), err);
        end
    endtask

    task automatic test_reset();
        init_n = 1'b0; start = 1'b0; tap_sel = 3'd0; seed = 6'd0; pre_len = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        init_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({done, err, mem_if.wr_en, mem_if.raddr, mem_if.waddr, mem_if.data_in}
            !== {1'b0, 1'b0, 1'b0, 8'd0, 8'd64, 8'd0}) begin
            errors++;
            $display("FAIL reset: done %b err %b wr_en %b raddr %0h waddr %0h data %0h expected 0 0 0 0 40 0",
                     done, err, mem_if.wr_en, mem_if.raddr, mem_if.waddr, mem_if.data_in);
        end
    endtask

    task automatic test_basic();
        int de, nw;
        run_frame(0, 6'h01, 7, 0, 0, de, nw);
        check_full("basic", de, nw);
        checks++;
        if (mem[64] !== fix_par(8'h5e) || mem[65] !== fix_par(8'h5c)) begin
            errors++;
            $display("FAIL basic_preamble: mem64 %0h mem65 %0h expected %0h %0h",
                     mem[64], mem[65], fix_par(8'h5e), fix_par(8'h5c));
        end
    endtask

    task automatic test_clamp();
        int de, nw;
        run_frame(1, 6'h15, 3, 0, 0, de, nw);
        check_full("clamp_low", de, nw);
        run_frame(4, 6'h3c, 20, 0, 0, de, nw);
        check_full("clamp_high", de, nw);
    endtask

    task automatic test_reject(input logic [2:0] ts, input logic [5:0] sd);
        bit seen;
        @(negedge clk);
        start = 1'b1; tap_sel = ts; seed = sd; pre_len = 5'd7;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (mem_if.wr_en) seen = 1'b1;
        end
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || seen) begin
            errors++;
            $display("FAIL reject_t%0d_s%0h: err %b done %b wr_seen %b expected 1 0 0", ts, sd, err, done, seen);
        end
    endtask

    task automatic test_err();
        int de, nw;
        test_reject(3'd6, 6'h05);
        test_reject(3'd2, 6'h00);
        run_frame(2, 6'h2b, 9, 0, 0, de, nw);
        check_full("after_reject", de, nw);
    endtask

    task automatic test_back_to_back();
        int de, nw;
        run_frame(0, 6'h01, 7, 20, 0, de, nw);
        check_full("busy_start", de, nw);
        run_frame(0, 6'h01, 7, 0, 30, de, nw);
        run_frame(5, 6'h07, 10, 0, 0, de, nw);
        check_full("rerun", de, nw);
    endtask

    task automatic test_round_trip();
        int de, nw, p;
        logic [5:0] sd, lf;
        logic [7:0] pt;
        bit bad;
        for (int ts = 0; ts < 6; ts++) begin
            sd = 6'($urandom_range(1, 63));
            p  = $urandom_range(0, 31);
            run_frame(ts, sd, p, 0, 0, de, nw);
            check_full("round_trip_run", de, nw);
            p = tb_clamp(p);
            lf = sd; bad = 1'b0;
            for (int c = 0; c < 64; c++) begin
                pt = mem[64 + c] ^ {2'b00, lf};
                if (c >= p && pt[6:0] !== mem[c - p][6:0]) bad = 1'b1;
                lf = {lf[4:0], ^(lf & tb_taps(ts))};
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL round_trip_t%0d: decrypted message differs from plaintext (seed %0h)", ts, sd);
            end
`ifdef ENC_PARITY_EN
            for (int c = 64; c < 128; c++) begin
                checks++;
                if (^mem[c] !== 1'b0) begin
                    errors++;
                    $display("FAIL parity_%0d: byte %0h has odd parity", c, mem[c]);
                end
            end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_clamp();
        test_err();
        test_back_to_back();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
